// File: rtl/eq_sample_collector_pkg.sv
// eq_sample_collector_pkg
//   Shared constants and the collector state type for the output-side
//   sample collector.
//   No ports (package).
package eq_sample_collector_pkg;

  localparam int SAMPLE_W        = 16;
  localparam int PHASE_PERIOD    = 64;
  localparam int FILTER_LATENCY  = 64;
  localparam int NUM_SAMPLES_DEF = 2001;
  localparam int FIFO_DEPTH_DEF  = 16;
  localparam int CNT_W_DEF       = 20;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } collector_state_e;

endpackage

// File: rtl/eq_sample_collector_if.sv
// eq_sample_collector_if
//   Valid/ready stream carrying captured samples out of the collector.
//   data  : FIFO head sample (valid while valid=1)
//   valid : head is present
//   ready : consumer accepts the head this cycle
interface eq_sample_collector_if
  import eq_sample_collector_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
) ();

  logic [DATA_W-1:0] data;
  logic              valid;
  logic              ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);

endinterface

// File: rtl/eq_sync_fifo.sv
// eq_sync_fifo
//   Synchronous first-word-fall-through FIFO. A write into a full FIFO is
//   accepted only when a read happens on the same edge.
//   clk, rst     : clock, synchronous active-high reset
//   wr_en_i      : write request, wr_data_i : write data
//   rd_en_i      : read request (ignored when empty)
//   rd_data_o    : head entry, forced to zero while empty
//   full_o, empty_o, count_o : status and occupancy
module eq_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  input  logic                       rd_en_i,
  output logic [DATA_W-1:0]          rd_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_wr_s, do_rd_s;

  // Pointers carry an extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign do_rd_s   = rd_en_i && !empty_o;
  assign do_wr_s   = wr_en_i && (!full_o || do_rd_s);
  assign rd_data_o = empty_o ? {DATA_W{1'b0}} : mem_q[rd_ptr_q[AW-1:0]];

  // Pointer next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_wr_s) begin
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_rd_s) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (do_wr_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/eq_sample_collector.sv
// eq_sample_collector
//   Regenerates the filter output strobe by delaying in_phase through a
//   clk_enable-gated delay line, captures filter_out on that strobe into a
//   FWFT FIFO and counts strobes until NUM_SAMPLES, then drains.
//   clk, rst        : clock, synchronous active-high reset
//   clk_enable_i    : gates delay-line shifting and capture
//   in_phase_i      : a sample entered the filter this cycle
//   filter_out_i    : signed filter output sample
//   ce_out_exp_o    : regenerated output strobe
//   m_if            : captured-sample stream (master)
//   sample_count_o  : strobes consumed (captured plus dropped)
//   done_o          : count reached NUM_SAMPLES (sticky)
//   drained_o       : done and FIFO emptied
//   overflow_o      : a strobe hit a full FIFO (sticky)
module eq_sample_collector
  import eq_sample_collector_pkg::*;
#(
  parameter int DATA_W      = SAMPLE_W,
  parameter int LATENCY     = FILTER_LATENCY,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF,
  parameter int NUM_SAMPLES = NUM_SAMPLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_enable_i,
  input  logic                     in_phase_i,
  input  logic signed [DATA_W-1:0] filter_out_i,
  output logic                     ce_out_exp_o,
  eq_sample_collector_if.master    m_if,
  output logic [CNT_W-1:0]         sample_count_o,
  output logic                     done_o,
  output logic                     drained_o,
  output logic                     overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [LATENCY-1:0] dly_q, dly_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               done_q, done_d;
  logic               overflow_q, overflow_d;
  collector_state_e   state_q, state_d;

  logic               cap_s, last_cap_s, pop_s, wr_ok_s, empty_after_s;
  logic               fifo_full_s, fifo_empty_s;
  logic [AW:0]        fifo_count_s, occ_next_s;
  logic [DATA_W-1:0]  fifo_rd_data_s;

  assign ce_out_exp_o = dly_q[LATENCY-1] & clk_enable_i;
  // Strobes after done are ignored entirely: no push, no count, no overflow.
  assign cap_s        = ce_out_exp_o && !done_q;
  assign last_cap_s   = cap_s && (count_q == CNT_W'(NUM_SAMPLES - 1));
  assign pop_s        = m_if.ready && !fifo_empty_s;
  assign wr_ok_s      = cap_s && (!fifo_full_s || pop_s);
  assign occ_next_s   = fifo_count_s + (wr_ok_s ? (AW+1)'(1) : (AW+1)'(0))
                                     - (pop_s   ? (AW+1)'(1) : (AW+1)'(0));
  assign empty_after_s = (occ_next_s == (AW+1)'(0));

  eq_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (cap_s),
    .wr_data_i (filter_out_i),
    .rd_en_i   (m_if.ready),
    .rd_data_o (fifo_rd_data_s),
    .full_o    (fifo_full_s),
    .empty_o   (fifo_empty_s),
    .count_o   (fifo_count_s)
  );

  assign m_if.data      = fifo_rd_data_s;
  assign m_if.valid     = !fifo_empty_s;
  assign sample_count_o = count_q;
  assign done_o         = done_q;
  assign overflow_o     = overflow_q;
  assign drained_o      = (state_q == ST_DONE);

  // Next-state for delay line, counter, sticky flags and collector FSM.
  always_comb begin
    dly_d      = dly_q;
    count_d    = count_q;
    done_d     = done_q;
    overflow_d = overflow_q;
    state_d    = state_q;

    if (clk_enable_i) begin
      dly_d[0] = in_phase_i;
      for (int i = 1; i < LATENCY; i++) begin
        dly_d[i] = dly_q[i-1];
      end
    end else begin
      dly_d = dly_q;
    end

    if (cap_s) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end

    done_d     = done_q | last_cap_s;
    overflow_d = overflow_q | (cap_s && fifo_full_s && !pop_s);

    case (state_q)
      ST_IDLE, ST_CAPTURE: begin
        if (last_cap_s) begin
          state_d = empty_after_s ? ST_DONE : ST_DRAIN;
        end else if (cap_s) begin
          state_d = ST_CAPTURE;
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (pop_s && (fifo_count_s == (AW+1)'(1))) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_q      <= '0;
      count_q    <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
      state_q    <= ST_IDLE;
    end else begin
      dly_q      <= dly_d;
      count_q    <= count_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

endmodule

// File: tb/tb_eq_sample_collector.sv
module tb_eq_sample_collector;
  import eq_sample_collector_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ce;
  logic        in_phase, in_phase2;
  logic [15:0] fout, fout2;
  logic        ce1, done1, drained1, ovf1;
  logic        ce2, done2, drained2, ovf2;
  logic [19:0] count1;
  logic [2:0]  count2;

  eq_sample_collector_if #(.DATA_W(16)) s1 ();
  eq_sample_collector_if #(.DATA_W(16)) s2 ();

  eq_sample_collector dut1 (
    .clk(clk), .rst(rst), .clk_enable_i(ce), .in_phase_i(in_phase),
    .filter_out_i(fout), .ce_out_exp_o(ce1), .m_if(s1.master),
    .sample_count_o(count1), .done_o(done1), .drained_o(drained1),
    .overflow_o(ovf1)
  );

  eq_sample_collector #(
    .LATENCY(4), .FIFO_DEPTH(4), .NUM_SAMPLES(4), .CNT_W(3)
  ) dut2 (
    .clk(clk), .rst(rst), .clk_enable_i(ce), .in_phase_i(in_phase2),
    .filter_out_i(fout2), .ce_out_exp_o(ce2), .m_if(s2.master),
    .sample_count_o(count2), .done_o(done2), .drained_o(drained2),
    .overflow_o(ovf2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q1[$];
  logic [15:0] q2[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every accepted head is compared with the queue front.
  always @(negedge clk) begin
    logic [15:0] e;
    if (s1.valid === 1'b1 && s1.ready === 1'b1) begin
      n_checks++;
      if (q1.size() == 0) begin
        n_fail++;
        $display("FAIL sb1_unexpected: got %0h expected none", s1.data);
      end else begin
        e = q1.pop_front();
        if (s1.data !== e) begin
          n_fail++;
          $display("FAIL sb1_data: got %0h expected %0h", s1.data, e);
        end
      end
    end
    if (s2.valid === 1'b1 && s2.ready === 1'b1) begin
      n_checks++;
      if (q2.size() == 0) begin
        n_fail++;
        $display("FAIL sb2_unexpected: got %0h expected none", s2.data);
      end else begin
        e = q2.pop_front();
        if (s2.data !== e) begin
          n_fail++;
          $display("FAIL sb2_data: got %0h expected %0h", s2.data, e);
        end
      end
    end
  end

  // n back-to-back phase pulses on dut1; captures land at edges 64..63+n
  // after the first pulse edge with values base, base+1, ...
  task automatic burst1(input int n, input logic [15:0] base, input bit pop_last);
    in_phase = 1'b1;
    tick();
    for (int k = 0; k <= 62 + n; k++) begin
      in_phase = (k + 1 < n);
      fout     = (k >= 63 && k <= 62 + n) ? base + 16'(k - 63) : 16'h0000;
      s1.ready = pop_last && (k == 62 + n);
      tick();
    end
    s1.ready = 1'b0;
    fout     = 16'h0000;
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b1; in_phase = 1'b0; in_phase2 = 1'b0;
    fout = 16'h0000; fout2 = 16'h0000;
    s1.ready = 1'b0; s2.ready = 1'b0;
    repeat (10) tick();

    // Reset state
    chk("rst_ce",      32'(ce1),      32'd0);
    chk("rst_valid",   32'(s1.valid), 32'd0);
    chk("rst_data",    32'(s1.data),  32'd0);
    chk("rst_count",   32'(count1),   32'd0);
    chk("rst_done",    32'(done1),    32'd0);
    chk("rst_drained", 32'(drained1), 32'd0);
    chk("rst_ovf",     32'(ovf1),     32'd0);
    chk("rst_valid2",  32'(s2.valid), 32'd0);
    rst = 1'b0;

    // Test 1: single strobe, 64-cycle latency
    in_phase = 1'b1; fout = 16'h1234;
    tick();
    in_phase = 1'b0;
    for (int k = 0; k <= 63; k++) begin
      chk("t1_ce", 32'(ce1), (k == 63) ? 32'd1 : 32'd0);
      if (k < 63) tick();
    end
    q1.push_back(16'h1234);
    tick();
    chk("t1_valid", 32'(s1.valid), 32'd1);
    chk("t1_data",  32'(s1.data),  32'h1234);
    chk("t1_count", 32'(count1),   32'd1);
    chk("t1_ce_lo", 32'(ce1),      32'd0);
    s1.ready = 1'b1;
    tick();
    chk("t1_empty", 32'(s1.valid), 32'd0);

    // Test 2: clk_enable low 5 cycles inside the latency window
    in_phase = 1'b1; fout = 16'hABCD;
    tick();
    in_phase = 1'b0;
    for (int k = 0; k <= 68; k++) begin
      ce = !(k >= 10 && k <= 14);
      chk("t2_ce", 32'(ce1), (k == 68) ? 32'd1 : 32'd0);
      if (k >= 10 && k <= 14) chk("t2_hold_count", 32'(count1), 32'd1);
      if (k < 68) tick();
    end
    q1.push_back(16'hABCD);
    tick();
    chk("t2_count", 32'(count1),   32'd2);
    chk("t2_data",  32'(s1.data),  32'hABCD);
    tick();
    chk("t2_empty", 32'(s1.valid), 32'd0);

    // Test 4: full FIFO, strobe and pop on the same edge
    s1.ready = 1'b0;
    reset_pulse();
    chk("t4_count0", 32'(count1), 32'd0);
    for (int i = 0; i < 17; i++) q1.push_back(16'd101 + 16'(i));
    burst1(17, 16'd101, 1'b1);
    chk("t4_ovf",   32'(ovf1),     32'd0);
    chk("t4_count", 32'(count1),   32'd17);
    chk("t4_valid", 32'(s1.valid), 32'd1);
    chk("t4_head",  32'(s1.data),  32'd102);
    s1.ready = 1'b1;
    repeat (16) tick();
    chk("t4_empty", 32'(s1.valid), 32'd0);
    chk("t4_sb",    32'(q1.size()), 32'd0);

    // Test 3: overflow with 17 strobes into 16 entries
    s1.ready = 1'b0;
    reset_pulse();
    for (int i = 1; i <= 16; i++) q1.push_back(16'(i));
    burst1(17, 16'd1, 1'b0);
    chk("t3_ovf",   32'(ovf1),     32'd1);
    chk("t3_count", 32'(count1),   32'd17);
    chk("t3_valid", 32'(s1.valid), 32'd1);
    chk("t3_head",  32'(s1.data),  32'd1);
    chk("t3_done",  32'(done1),    32'd0);
    s1.ready = 1'b1;
    repeat (16) tick();
    chk("t3_empty", 32'(s1.valid), 32'd0);
    chk("t3_sb",    32'(q1.size()), 32'd0);

    // Test 6: reset with 8 entries queued
    s1.ready = 1'b0;
    reset_pulse();
    burst1(8, 16'h8001, 1'b0);
    chk("t6_pre_count", 32'(count1),   32'd8);
    chk("t6_pre_valid", 32'(s1.valid), 32'd1);
    chk("t6_pre_data",  32'(s1.data),  32'h8001);
    rst = 1'b1;
    tick();
    chk("t6_valid",   32'(s1.valid), 32'd0);
    chk("t6_data",    32'(s1.data),  32'd0);
    chk("t6_count",   32'(count1),   32'd0);
    chk("t6_done",    32'(done1),    32'd0);
    chk("t6_ovf",     32'(ovf1),     32'd0);
    chk("t6_drained", 32'(drained1), 32'd0);
    rst = 1'b0;
    q1.push_back(16'h7FFF);
    burst1(1, 16'h7FFF, 1'b0);
    chk("t6_re_count", 32'(count1),  32'd1);
    chk("t6_re_data",  32'(s1.data), 32'h7FFF);
    s1.ready = 1'b1;
    tick();
    chk("t6_re_empty", 32'(s1.valid), 32'd0);

    // Test 5: NUM_SAMPLES=4 build, 6 strobes, consumer always ready
    s2.ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      in_phase2 = 1'b1;
      fout2     = 16'h0A00 + 16'(i);
      if (i <= 4) q2.push_back(16'h0A00 + 16'(i));
      tick();
      in_phase2 = 1'b0;
      repeat (4) tick();
      chk("t5_count", 32'(count2), (i < 4) ? 32'(i) : 32'd4);
      chk("t5_done",  32'(done2),  (i >= 4) ? 32'd1 : 32'd0);
      if (i == 4) chk("t5_draining", 32'(drained2), 32'd0);
      tick();
      chk("t5_drained", 32'(drained2), (i >= 4) ? 32'd1 : 32'd0);
      chk("t5_valid",   32'(s2.valid), 32'd0);
      chk("t5_ovf",     32'(ovf2),     32'd0);
    end
    chk("t5_sb", 32'(q2.size()), 32'd0);

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
